// File: rtl/bas_pkg.sv
// Shared widths, tag codes and pipeline payload types for the BAS fitness evaluator.
package bas_pkg;

  localparam int unsigned POS_W  = 16;
  localparam int unsigned DIFF_W = POS_W + 1;
  localparam int unsigned SQ_W   = 2 * POS_W;
  localparam int unsigned SUM_W  = SQ_W + 1;
  localparam int unsigned FIT_W  = 40;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [TAG_W-1:0] TAG_BODY  = 2'd0;
  localparam logic [TAG_W-1:0] TAG_LEFT  = 2'd1;
  localparam logic [TAG_W-1:0] TAG_RIGHT = 2'd2;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [TAG_W-1:0] tag;
  } cand_t;

  // Diffs are two's complement in DIFF_W bits.
  typedef struct packed {
    logic [DIFF_W-1:0] dx;
    logic [DIFF_W-1:0] dy;
    cand_t             c;
  } s1_t;

  typedef struct packed {
    logic [SQ_W-1:0] sqx;
    logic [SQ_W-1:0] sqy;
    cand_t           c;
  } s2_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    cand_t            c;
  } s3_t;

  // Magnitude of a two's complement diff; always fits POS_W bits.
  function automatic logic [POS_W-1:0] diff_mag(input logic [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? POS_W'(-d) : POS_W'(d);
  endfunction

endpackage

// File: rtl/bas_fit_stage.sv
// Generic valid/ready pipeline register; ready_c_o is combinational from ready_i.
module bas_fit_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_i,
  output logic         ready_c_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready_c_o = !valid_q || ready_i;
  assign valid_o   = valid_q;
  assign data_o    = data_q;

  // Load whenever empty or draining; payload only moves with a valid beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_c_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/bas_fitness_eval.sv
// Three-stage squared-distance cost evaluator for the BAS core.
// Optional best-candidate tracking enabled by defining BAS_FIT_BEST_EN.
module bas_fitness_eval
  import bas_pkg::*;
#(
  parameter logic [POS_W-1:0] TARGET_X = 16'h8000,
  parameter logic [POS_W-1:0] TARGET_Y = 16'h8000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_x,
  input  logic [POS_W-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FIT_W-1:0] out_value,
  output logic [POS_W-1:0] out_x,
  output logic [POS_W-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] eval_count
`ifdef BAS_FIT_BEST_EN
  ,
  output logic             best_valid,
  output logic [FIT_W-1:0] best_value,
  output logic [POS_W-1:0] best_x,
  output logic [POS_W-1:0] best_y
`endif
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;
  logic xfer;
  logic [POS_W-1:0] mag_x, mag_y;
  logic [CNT_W-1:0] count_d, count_q;

  // Inter-stage arithmetic: diffs, squares of magnitudes, sum.
  always_comb begin
    s1_d.dx = {1'b0, in_x} - {1'b0, TARGET_X};
    s1_d.dy = {1'b0, in_y} - {1'b0, TARGET_Y};
    s1_d.c  = '{x: in_x, y: in_y, tag: in_tag};
    mag_x   = diff_mag(s1_q.dx);
    mag_y   = diff_mag(s1_q.dy);
    s2_d.sqx = SQ_W'(mag_x) * SQ_W'(mag_x);
    s2_d.sqy = SQ_W'(mag_y) * SQ_W'(mag_y);
    s2_d.c   = s1_q.c;
    s3_d.sum = SUM_W'(s2_q.sqx) + SUM_W'(s2_q.sqy);
    s3_d.c   = s2_q.c;
  end

  bas_fit_stage #(.W($bits(s1_t))) u_s1 (
    .clock(clock), .reset(reset),
    .valid_i(in_valid), .ready_c_o(s1_ready), .data_i(s1_d),
    .valid_o(s1_valid), .ready_i(s2_ready), .data_o(s1_q)
  );

  bas_fit_stage #(.W($bits(s2_t))) u_s2 (
    .clock(clock), .reset(reset),
    .valid_i(s1_valid), .ready_c_o(s2_ready), .data_i(s2_d),
    .valid_o(s2_valid), .ready_i(s3_ready), .data_o(s2_q)
  );

  bas_fit_stage #(.W($bits(s3_t))) u_s3 (
    .clock(clock), .reset(reset),
    .valid_i(s2_valid), .ready_c_o(s3_ready), .data_i(s3_d),
    .valid_o(s3_valid), .ready_i(out_ready), .data_o(s3_q)
  );

  assign in_ready  = s1_ready && !reset;
  assign out_valid = s3_valid;
  assign out_value = FIT_W'(s3_q.sum);
  assign out_x     = s3_q.c.x;
  assign out_y     = s3_q.c.y;
  assign out_tag   = s3_q.c.tag;
  assign xfer      = s3_valid && out_ready;

  // Saturating completion counter; load takes priority over a same-cycle transfer.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (xfer && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign eval_count = count_q;

`ifdef BAS_FIT_BEST_EN
  logic             best_valid_d, best_valid_q;
  logic [FIT_W-1:0] best_value_d, best_value_q;
  logic [POS_W-1:0] best_x_d, best_x_q, best_y_d, best_y_q;

  // Strictly-lower cost replaces the best; ties keep the earlier entry.
  always_comb begin
    best_valid_d = best_valid_q;
    best_value_d = best_value_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    if (load) begin
      best_valid_d = 1'b0;
      best_value_d = '0;
      best_x_d     = '0;
      best_y_d     = '0;
    end else if (xfer && (!best_valid_q || (out_value < best_value_q))) begin
      best_valid_d = 1'b1;
      best_value_d = out_value;
      best_x_d     = out_x;
      best_y_d     = out_y;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      best_valid_q <= 1'b0;
      best_value_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else begin
      best_valid_q <= best_valid_d;
      best_value_q <= best_value_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
    end
  end

  assign best_valid = best_valid_q;
  assign best_value = best_value_q;
  assign best_x     = best_x_q;
  assign best_y     = best_y_q;
`endif

endmodule

// File: tb/tb_bas_fitness_eval.sv
// Directed self-checking bench for bas_fitness_eval (best tracking checked when BAS_FIT_BEST_EN is defined).
module tb_bas_fitness_eval;

  logic        clock = 1'b0;
  logic        reset, load, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_x, in_y, out_x, out_y, eval_count;
  logic [1:0]  in_tag, out_tag;
  logic [39:0] out_value;
`ifdef BAS_FIT_BEST_EN
  logic        best_valid;
  logic [39:0] best_value;
  logic [15:0] best_x, best_y;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  tag;
    logic [39:0] cost;
  } exp_t;

  exp_t pend_q[$];
  exp_t exp_q[$];

  always #5 clock = ~clock;

  bas_fitness_eval dut (
    .clock(clock), .reset(reset), .load(load),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_x(out_x), .out_y(out_y), .out_tag(out_tag),
    .eval_count(eval_count)
`ifdef BAS_FIT_BEST_EN
    , .best_valid(best_valid), .best_value(best_value),
    .best_x(best_x), .best_y(best_y)
`endif
  );

  task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic logic [39:0] model_cost(input logic [15:0] x, input logic [15:0] y);
    longint dx, dy;
    dx = longint'(x) - 64'sd32768;
    dy = longint'(y) - 64'sd32768;
    return 40'(dx * dx + dy * dy);
  endfunction

  task automatic push(input logic [15:0] x, input logic [15:0] y,
                      input logic [1:0] t, input logic [39:0] c);
    exp_t e;
    e.x = x; e.y = y; e.tag = t; e.cost = c;
    pend_q.push_back(e);
  endtask

  // One cycle from posedge+1: drive, settle, score handshakes, advance to next posedge+1.
  // mode: 0 = out_ready low, 1 = high, 2 = random.
  task automatic step(input int mode, input string name);
    exp_t e;
    in_valid = (pend_q.size() != 0);
    if (in_valid) begin
      in_x = pend_q[0].x; in_y = pend_q[0].y; in_tag = pend_q[0].tag;
    end
    out_ready = (mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1));
    #1;
    if (in_valid && in_ready) exp_q.push_back(pend_q.pop_front());
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({name, "_spurious_out"}, 80'(out_value), 80'h0_dead_beef);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_out"}, {out_x, out_y, out_tag, out_value}, {e.x, e.y, e.tag, e.cost});
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    load = 1'b0;
  endtask

  task automatic drain(input int mode, input string name);
    int n;
    n = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      step(mode, name);
      n++;
    end
    chk({name, "_drained"}, 80'(pend_q.size() + exp_q.size()), 80'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [73:0] held;
    reset = 1'b1; load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_tag = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_value", 80'(out_value), 80'd0);
    chk("rst_count", 80'(eval_count), 80'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 80'(in_ready), 80'd1);

    // 1: single candidate, latency 3
    in_valid = 1'b1; in_x = 16'h6500; in_y = 16'h7D00; in_tag = 2'd1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("lat_c1_valid", 80'(out_valid), 80'd0);
    @(posedge clock); #1;
    chk("lat_c2_valid", 80'(out_valid), 80'd0);
    @(posedge clock); #1;
    chk("lat_c3_valid", 80'(out_valid), 80'd1);
    chk("single_value", 80'(out_value), 80'h00_02E2_0000);
    chk("single_tag", 80'(out_tag), 80'd1);
    chk("single_xy", 80'({out_x, out_y}), 80'h6500_7D00);
    @(posedge clock); #1;
    chk("single_after_valid", 80'(out_valid), 80'd0);
    chk("single_count", 80'(eval_count), 80'd1);

    // 2: arithmetic bounds
    push(16'h0000, 16'h0000, 2'd0, 40'h00_8000_0000);
    push(16'hFFFF, 16'hFFFF, 2'd2, 40'h00_7FFE_0002);
    push(16'h8000, 16'h8000, 2'd1, 40'h00_0000_0000);
    drain(1, "bounds");
    chk("bounds_count", 80'(eval_count), 80'd4);

    // 3: backpressure, 3 in flight max, held outputs
    load = 1'b1;
    step(1, "bp_load");
    chk("bp_load_count", 80'(eval_count), 80'd0);
    push(16'h8100, 16'h8000, 2'd0, 40'h00_0001_0000);
    push(16'h8000, 16'h7E00, 2'd1, 40'h00_0004_0000);
    push(16'h8300, 16'h8000, 2'd2, 40'h00_0009_0000);
    push(16'h8000, 16'h8400, 2'd0, 40'h00_0010_0000);
    push(16'h7B00, 16'h8000, 2'd1, 40'h00_0019_0000);
    repeat (4) step(0, "bp_fill");
    chk("bp_accepted", 80'(exp_q.size()), 80'd3);
    chk("bp_out_valid", 80'(out_valid), 80'd1);
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 80'(in_ready), 80'd0);
    held = {out_x, out_y, out_tag, out_value};
    chk("bp_head", 80'(held), 80'({16'h8100, 16'h8000, 2'd0, 40'h00_0001_0000}));
    for (int i = 0; i < 3; i++) begin
      step(0, "bp_stall");
      chk("bp_hold", 80'({out_x, out_y, out_tag, out_value}), 80'(held));
      chk("bp_hold_valid", 80'(out_valid), 80'd1);
    end
    chk("bp_still_3", 80'(exp_q.size()), 80'd3);
    drain(1, "bp");
    chk("bp_count", 80'(eval_count), 80'd5);

    // 4: streaming with random consumer
    load = 1'b1;
    step(1, "st_load");
    for (int i = 0; i < 100; i++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      push(rx, ry, 2'($urandom_range(0, 2)), model_cost(rx, ry));
    end
    drain(2, "stream");
    chk("stream_count", 80'(eval_count), 80'd100);

    // 5: reset with pipeline full
    push(16'h1234, 16'h5678, 2'd0, model_cost(16'h1234, 16'h5678));
    push(16'h9ABC, 16'hDEF0, 2'd1, model_cost(16'h9ABC, 16'hDEF0));
    push(16'h0F0F, 16'hF0F0, 2'd2, model_cost(16'h0F0F, 16'hF0F0));
    repeat (3) step(0, "rst_fill");
    chk("rst_fill_n", 80'(exp_q.size()), 80'd3);
    reset = 1'b1; out_ready = 1'b0;
    #1;
    chk("rst_mid_in_ready", 80'(in_ready), 80'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_mid_valid", 80'(out_valid), 80'd0);
    chk("rst_mid_count", 80'(eval_count), 80'd0);
    chk("rst_mid_value", 80'(out_value), 80'd0);
    #1;
    chk("rst_mid_in_ready1", 80'(in_ready), 80'd1);
    exp_q.delete();
    repeat (8) step(1, "rst_quiet");
    chk("rst_quiet_valid", 80'(out_valid), 80'd0);
    chk("rst_quiet_count", 80'(eval_count), 80'd0);

    // load coinciding with transfer wins; pipeline not flushed
    push(16'h8000, 16'h8000, 2'd0, 40'h00_0000_0000);
    push(16'h8200, 16'h8000, 2'd2, 40'h00_0004_0000);
    repeat (3) step(0, "ld_fill");
    chk("ld_fill_valid", 80'(out_valid), 80'd1);
    load = 1'b1;
    step(1, "ld_xfer");
    chk("ld_wins_count", 80'(eval_count), 80'd0);
    drain(1, "ld_rest");
    chk("ld_rest_count", 80'(eval_count), 80'd1);

`ifdef BAS_FIT_BEST_EN
    // 6: best tracking, strict less-than, ties keep earlier
    load = 1'b1;
    step(1, "best_load");
    chk("best_clr_valid", 80'(best_valid), 80'd0);
    chk("best_clr_value", 80'(best_value), 80'd0);
    push(16'h8020, 16'h8010, 2'd0, 40'h500);
    push(16'h8010, 16'h8010, 2'd1, 40'h200);
    push(16'h7FF0, 16'h8010, 2'd2, 40'h200);
    push(16'h8020, 16'h8000, 2'd0, 40'h400);
    drain(1, "best");
    chk("best_valid", 80'(best_valid), 80'd1);
    chk("best_value", 80'(best_value), 80'h200);
    chk("best_xy", 80'({best_x, best_y}), 80'h8010_8010);
    load = 1'b1;
    step(1, "best_reload");
    chk("best_reload_valid", 80'(best_valid), 80'd0);
    chk("best_reload_value", 80'(best_value), 80'd0);
    chk("best_reload_count", 80'(eval_count), 80'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
